// File: rtl/sysid_read_checker.sv
// sysid_read_checker: Avalon-MM read master that checks the system-ID slave.
//
// Reads word 0 (build ID) and then word 1 (build timestamp) from the sysid
// slave. It compares both words against EXPECTED_ID / EXPECTED_TS and reports
// the result. The captured words are also kept for software to inspect.
//
// Ports:
//   clock            system clock, all logic on the rising edge
//   reset            synchronous, active-high reset
//   start            one-cycle pulse that begins a check sequence (ignored unless idle)
//   avm_address      word select: 0 = ID, 1 = timestamp
//   avm_read         read strobe
//   avm_readdata     slave read data, captured when read=1 and waitrequest=0
//   avm_waitrequest  slave stall
//   busy             sequence in progress
//   done             one-cycle pulse when the sequence ends
//   pass             last sequence matched both words (sticky until next start)
//   id_ok / ts_ok    last captured ID / timestamp matched
//   timeout_err      last sequence aborted by a waitrequest timeout
//   id_value         captured ID word
//   ts_value         captured timestamp word
//   retries          (SYSID_READ_CHECKER_RETRY_EN only) attempts used beyond the first
//
// Build option:
//   SYSID_READ_CHECKER_RETRY_EN - when defined, a failed attempt is retried up to
//   MAX_RETRIES times. There is one idle cycle with avm_read=0 between attempts.
//   done pulses only on a pass or when the retries are exhausted.

module sysid_read_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h12345678,
  parameter logic [31:0] EXPECTED_TS    = 32'h5CDB1F3E,
  parameter int unsigned TIMEOUT_CYCLES = 16,  // 1..65535
  parameter int unsigned MAX_RETRIES    = 3    // 0..15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
`ifdef SYSID_READ_CHECKER_RETRY_EN
  ,
  output logic [3:0]  retries
`endif
);

  // Last counter value before the limit: a stall seen here is the
  // TIMEOUT_CYCLES-th one and aborts the read.
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRdId,
    StRdTs,
    StFinish,
    StRetry
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        pass_q, pass_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        timeout_q, timeout_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;
  logic [3:0]  retry_q, retry_d;

  // An attempt ends on RD_TS completion or on a timeout in either read.
  logic attempt_end;
  logic attempt_ok;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pass_d      = pass_q;
    id_ok_d     = id_ok_q;
    ts_ok_d     = ts_ok_q;
    timeout_d   = timeout_q;
    id_value_d  = id_value_q;
    ts_value_d  = ts_value_q;
    retry_d     = retry_q;
    attempt_end = 1'b0;
    attempt_ok  = 1'b0;
    avm_address = 1'b0;
    avm_read    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StRdId;
          pass_d    = 1'b0;
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
          timeout_d = 1'b0;
          cnt_d     = '0;
          retry_d   = '0;
        end
      end

      StRdId: begin
        busy     = 1'b1;
        avm_read = 1'b1;
        if (!avm_waitrequest) begin
          id_value_d = avm_readdata;
          id_ok_d    = (avm_readdata == EXPECTED_ID);
          cnt_d      = '0;
          state_d    = StRdTs;
        end else if (cnt_q == TimeoutLast) begin
          timeout_d   = 1'b1;
          attempt_end = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      StRdTs: begin
        busy        = 1'b1;
        avm_read    = 1'b1;
        avm_address = 1'b1;
        if (!avm_waitrequest) begin
          ts_value_d  = avm_readdata;
          ts_ok_d     = (avm_readdata == EXPECTED_TS);
          attempt_ok  = id_ok_q && (avm_readdata == EXPECTED_TS);
          attempt_end = 1'b1;
        end else if (cnt_q == TimeoutLast) begin
          timeout_d   = 1'b1;
          attempt_end = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      StFinish: begin
        done    = 1'b1;
        state_d = StIdle;
      end

      StRetry: begin
        busy    = 1'b1;
        state_d = StRdId;
      end

      default: state_d = StIdle;
    endcase

    if (attempt_end) begin
      pass_d  = attempt_ok;
      state_d = StFinish;
`ifdef SYSID_READ_CHECKER_RETRY_EN
      if (!attempt_ok && (retry_q < 4'(MAX_RETRIES))) begin
        retry_d   = retry_q + 4'd1;
        pass_d    = 1'b0;
        id_ok_d   = 1'b0;
        ts_ok_d   = 1'b0;
        timeout_d = 1'b0;
        cnt_d     = '0;
        state_d   = StRetry;
      end
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      pass_q     <= 1'b0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      timeout_q  <= 1'b0;
      id_value_q <= '0;
      ts_value_q <= '0;
      retry_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pass_q     <= pass_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      timeout_q  <= timeout_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
      retry_q    <= retry_d;
    end
  end

  assign pass        = pass_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout_err = timeout_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;

`ifdef SYSID_READ_CHECKER_RETRY_EN
  assign retries = retry_q;
`else
  logic unused_retry;
  assign unused_retry = ^retry_q;
`endif

endmodule

// File: doc/sysid_read_checker.md
Name: sysid_read_checker

Overview:
- Avalon-MM read master that sequences two reads of the system-ID slave: word 0 is the ID and word 1 is the timestamp.
- Compares both words against expected constants and reports pass/fail with captured values.
- Sits between the boot/control logic and the sysid slave. Software or hardware pulses start and then polls done/pass before trusting the hardware build.

Parameters:
- EXPECTED_ID, 32'h12345678, value required at address 0.
- EXPECTED_TS, 32'h5CDB1F3E, value required at address 1.
- TIMEOUT_CYCLES, 16, max cycles one read may be held off by waitrequest; legal range 1..65535.
- MAX_RETRIES, 3, retry attempts when SYSID_READ_CHECKER_RETRY_EN is defined; legal range 0..15.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse, begins a check sequence
- avm_address  out  1  word select: 0 = ID, 1 = timestamp
- avm_read  out  1  read strobe
- avm_readdata  in  32  slave read data
- avm_waitrequest  in  1  slave stall
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse when sequence ends
- pass  out  1  last sequence matched both words (sticky until next start)
- id_ok  out  1  last captured ID == EXPECTED_ID
- ts_ok  out  1  last captured timestamp == EXPECTED_TS
- timeout_err  out  1  last sequence aborted by timeout
- id_value  out  32  captured ID word
- ts_value  out  32  captured timestamp word

Behaviour:
- Reset, sampled on a clock edge with reset=1:
  - state returns to IDLE.
  - All outputs clear to 0, including id_value and ts_value.
  - Reset overrides any in-flight read. avm_read is 0 in the cycle after reset is sampled.
- Read transfer protocol:
  - Zero-latency reads: a transfer completes in the cycle where avm_read=1 and avm_waitrequest=0.
  - avm_readdata is captured in that cycle.
  - avm_address and avm_read stay stable while waitrequest=1.
- States:
  - IDLE: busy=0, avm_read=0. start=1 moves to RD_ID. On that transition, pass/id_ok/ts_ok/timeout_err clear, the timeout counter clears and the retry count clears.
  - RD_ID: avm_address=0, avm_read=1, busy=1. On completion: capture id_value, set id_ok = (data==EXPECTED_ID), clear the timeout counter, go to RD_TS.
  - RD_TS: avm_address=1, avm_read=1. On completion: capture ts_value, set ts_ok, go to FINISH.
  - FINISH: one cycle. done=1, pass = id_ok & ts_ok, busy=0, avm_read=0. Next state is IDLE.
- Timeout:
  - In RD_ID or RD_TS, the counter increments each cycle waitrequest=1.
  - When the counter reaches TIMEOUT_CYCLES while waitrequest is still 1: drop avm_read, set timeout_err=1, go to FINISH.
  - pass=0 on a timeout. The ok flag of the unread word stays 0.
- Latency:
  - With no waitrequest, start at cycle N gives avm_read in cycles N+1 and N+2; done at N+3.
  - Each waitrequest cycle adds 1.
- Boundaries:
  - start while busy is ignored.
  - start in the FINISH cycle is ignored.
  - start coincident with reset is ignored; reset wins.
  - If waitrequest is deasserted in the same cycle the counter hits the limit, the transfer completes and no timeout is flagged.
- Counter width: 16 bits, no wrap reachable within the legal parameter range.

Optional Feature:
- Macro: SYSID_READ_CHECKER_RETRY_EN
- Defined:
  - On a mismatch or timeout after RD_TS or a timeout, if retry count < MAX_RETRIES: increment the count, clear ok/timeout flags, return to RD_ID (one idle cycle with avm_read=0 between attempts).
  - No done is pulsed between attempts. done pulses only on a pass or on retry exhaustion.
  - Extra output port `retries` (4 bits, reset 0) reports attempts used.
- Not defined: single attempt, no retries port, behaviour exactly as above.

Test Plan:
- Slave returns 0x12345678 / 0x5CDB1F3E, waitrequest=0, start pulse -> done at start+3, pass=1, id_ok=1, ts_ok=1, id_value/ts_value equal the returned data.
- Slave returns timestamp 0x5CDB1F3F -> done, pass=0, id_ok=1, ts_ok=0, ts_value=0x5CDB1F3F.
- waitrequest held 3 cycles on each read -> address/read stable during stall, done at start+9, pass=1.
- waitrequest stuck high on the ID read -> avm_read drops after 16 stall cycles, timeout_err=1, pass=0, done pulses once.
- start repeated while busy, then reset asserted mid-RD_TS -> the extra start is ignored; the cycle after reset sees all outputs 0 and avm_read=0; a fresh start runs a clean pass.
- With SYSID_READ_CHECKER_RETRY_EN: first attempt returns a bad ID, second returns correct words -> single done, pass=1, retries=1. All-bad slave -> done after 4 attempts, retries=3, pass=0.
